uart_tx_tick: RTL and testbench

UART_TX_TICK -- requirements
Module: uart_tx_tick

---
 rtl/uart_tx_tick.sv | 137 +++++++++++++
 tb/tb_uart_tx_tick.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_tick.sv
// Tick-paced UART transmitter: accepts a word on valid/ready, then sends
// start, DATA_BITS data bits LSB first, optional parity and STOP_BITS stop bits.
module uart_tx_tick #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_srst,
    input  logic                 i_tick,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam int            CW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);

    state_t                state;
    logic [DATA_BITS-1:0]  shreg;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  par;

    // Handshake: a word is taken on any rising edge where i_valid and o_ready
    // are both high; o_ready is high exactly while the FSM sits in IDLE.
    assign o_ready = (state == S_IDLE);
    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_srst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                // A tick coinciding with acceptance is dropped: ARM waits for the next one.
                S_IDLE: begin
                    if (i_valid) begin
                        shreg    <= i_data;
                        par      <= (^i_data) ^ ODD;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_tick) begin
                        o_tx  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (i_tick) begin
                        o_tx  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                o_tx  <= par;
                                state <= S_PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (i_tick) begin
                        o_tx  <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (i_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            stop_cnt <= 1'b0;
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: four parameter variants share one stimulus stream and
// are checked cycle by cycle and frame by frame against a bit-list model.
module tb_uart_tx_tick;

    localparam int NI = 4;
    localparam int W  = 18;

    function automatic int db_of(input int k);  return (k == 3) ? 5 : 8; endfunction
    function automatic int pe_of(input int k);  return (k == 0) ? 0 : 1; endfunction
    function automatic int po_of(input int k);  return (k == 2) ? 1 : 0; endfunction
    function automatic int sb_of(input int k);  return (k == 1) ? 2 : 1; endfunction
    function automatic int len_of(input int k); return 1 + db_of(k) + pe_of(k) + sb_of(k); endfunction

    // Line levels of one frame, element 0 first: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame_of(input int k, input logic [7:0] d);
        logic [15:0] f;
        int p;
        int ones;
        f = '0;
        p = 1;
        ones = 0;
        for (int i = 0; i < db_of(k); i++) begin
            f[p] = d[i];
            ones += int'(d[i]);
            p++;
        end
        if (pe_of(k) == 1) begin
            f[p] = ((ones % 2) != po_of(k));
            p++;
        end
        for (int i = 0; i < sb_of(k); i++) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic srst = 1'b0;
    logic tick = 1'b0;
    logic valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [NI-1:0] ready, tx, busy, done;
    logic [NI-1:0][2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int tmo_count = 0;
    int tmo_seen = 0;
    int cyc = 0;
    int tick_period = 16;
    bit scramble = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB = db_of(g);
        uart_tx_tick #(
            .DATA_BITS (DB),
            .PARITY_EN (pe_of(g)),
            .PARITY_ODD(po_of(g)),
            .STOP_BITS (sb_of(g))
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_srst (srst),
            .i_tick (tick),
            .i_valid(valid),
            .i_data (data[DB-1:0]),
            .o_ready(ready[g]),
            .o_tx   (tx[g]),
            .o_busy (busy[g]),
            .o_done (done[g]),
            .o_state(state_dbg[g])
        );
    end

    logic [W-1:0] exp_q[$];

    function automatic int find_entry(input int k);
        for (int i = 0; i < exp_q.size(); i++)
            if (int'(exp_q[i][17:16]) == k) return i;
        return -1;
    endfunction

    task automatic chk(input int k, input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", nm, k, $time, act, exp);
        end
    endtask

    bit          m_busy [NI];
    bit          m_done [NI];
    bit          m_new  [NI];
    int          m_pos  [NI] = '{-1, -1, -1, -1};
    logic [15:0] rx     [NI];

    // Monitor: compare outputs with the model state, then advance the model
    // with the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        int idx;
        logic eb;
        logic ed;
        logic [W-1:0] ent;
        if (tmo_count != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL timeout at %0t: got %0d expired waits expected 0", $time, tmo_count - tmo_seen);
            tmo_seen = tmo_count;
        end
        for (int k = 0; k < NI; k++) begin
            eb = rst_n && m_busy[k];
            ed = rst_n && m_done[k];
            chk(k, "busy", busy[k], eb);
            chk(k, "ready", ready[k], !eb);
            chk(k, "done", done[k], ed);
            chk(k, "state_idle", state_dbg[k] == 3'd0, !eb);
            if (!rst_n || m_pos[k] < 0) chk(k, "tx_idle", tx[k], 1'b1);
            else if (m_new[k]) rx[k][m_pos[k]] = tx[k];
            else chk(k, "tx_hold", tx[k], rx[k][m_pos[k]]);
            if (ed) begin
                idx = find_entry(k);
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL frame dut%0d at %0t: got %b expected no frame", k, $time, rx[k]);
                end else begin
                    ent = exp_q[idx];
                    exp_q.delete(idx);
                    if (rx[k] !== ent[15:0]) begin
                        errors++;
                        $display("FAIL frame dut%0d at %0t: got %b expected %b", k, $time, rx[k], ent[15:0]);
                    end
                end
            end
            m_new[k] = 1'b0;
            if (!rst_n || srst) begin
                if (m_busy[k]) begin
                    idx = find_entry(k);
                    if (idx >= 0) exp_q.delete(idx);
                end
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_pos[k]  = -1;
            end else begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (valid) begin
                        m_busy[k] = 1'b1;
                        m_pos[k]  = -1;
                        rx[k]     = '0;
                        exp_q.push_back({2'(k), frame_of(k, data)});
                    end
                end else if (tick) begin
                    if (m_pos[k] == len_of(k) - 1) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_pos[k]  = -1;
                    end else begin
                        m_pos[k]++;
                        m_new[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = (tick_period == 0) ? ($urandom_range(0, 3) == 0) : ((cyc % tick_period) == 0);
        if (scramble && !valid) data = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input bit tick_now);
        valid = 1'b1;
        data  = d;
        if (tick_now) tick = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!((&ready) && !(|busy)) && n < max_cyc) begin
            step();
            n++;
        end
        if (!((&ready) && !(|busy))) tmo_count++;
    endtask

    initial begin
        int n;
        repeat (3) step();
        rst_n = 1'b1;

        tick_period = 16;
        send(8'hA5, 1'b0);
        wait_idle(3000);

        send(8'h5A, 1'b1);
        wait_idle(3000);

        valid = 1'b1;
        data  = 8'h00;
        n = 0;
        while (ready[0] && n < 50) begin step(); n++; end
        if (ready[0]) tmo_count++;
        data = 8'hFF;
        n = 0;
        while (!ready[0] && n < 1000) begin step(); n++; end
        if (!ready[0]) tmo_count++;
        step();
        valid = 1'b0;
        wait_idle(3000);

        send(8'hA5, 1'b0);
        repeat (50) step();
        data = 8'h3C;
        wait_idle(3000);

        send(8'hA5, 1'b0);
        repeat (64) step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        send(8'h96, 1'b0);
        wait_idle(3000);

        send(8'h81, 1'b0);
        repeat (60) step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        send(8'hC3, 1'b0);
        wait_idle(3000);

        scramble = 1'b1;
        for (int it = 0; it < 60; it++) begin
            tick_period = $urandom_range(0, 6);
            data  = 8'($urandom);
            valid = 1'b1;
            repeat ($urandom_range(1, 30)) step();
            valid = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                srst = 1'b1;
                step();
                srst = 1'b0;
            end
            repeat ($urandom_range(0, 40)) step();
        end
        wait_idle(5000);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog at %0t: got no finish expected finish", $time);
        $fatal(1);
    end

endmodule
